// File: rtl/blinker_ctrl_pkg.sv
// Shared types for the turn-signal/hazard controller: FSM states, Status codes and lever codes.
package blinker_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RIGHT  = 3'd1,
    S_LEFT   = 3'd2,
    S_HAZARD = 3'd3,
    S_COMF_R = 3'd4,
    S_COMF_L = 3'd5
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_R    = 2'b01;
  localparam logic [1:0] ST_L    = 2'b10;
  localparam logic [1:0] ST_HAZ  = 2'b11;

  localparam logic [1:0] LEV_OFF = 2'b00;
  localparam logic [1:0] LEV_R   = 2'b01;
  localparam logic [1:0] LEV_L   = 2'b10;
  localparam logic [1:0] LEV_INV = 2'b11;

  // Comfort states report the direction they are finishing.
  function automatic logic [1:0] status_of(state_t s);
    logic [1:0] st;
    st = ST_IDLE;
    case (s)
      S_RIGHT, S_COMF_R: st = ST_R;
      S_LEFT,  S_COMF_L: st = ST_L;
      S_HAZARD:          st = ST_HAZ;
      default:           st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/blinker_ctrl_if.sv
// Switch-input / lamp-output bundle of the blinker controller.
interface blinker_ctrl_if #(
  parameter int FCNT_W = 4
);
  logic              E;
  logic [1:0]        ADI;
  logic              tick;
  logic              blink;
  logic              D;
  logic              I;
  logic [1:0]        Status;
  logic [FCNT_W-1:0] flash_cnt;

  modport master (
    output E, ADI,
    input  tick, blink, D, I, Status, flash_cnt
  );

  modport slave (
    input  E, ADI,
    output tick, blink, D, I, Status, flash_cnt
  );
endinterface

// File: rtl/blink_prescaler.sv
// Half-period timebase: free-running tick, blink phase toggled on each wrap while running.
module blink_prescaler #(
  parameter int HALF = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic blink
);
  localparam int CW = $clog2(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // clr restarts the phase: count from 0 with lamps on (unless stopping).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      blink <= run;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (!run)
        blink <= 1'b0;
      else if (tick)
        blink <= ~blink;
    end
  end
endmodule

// File: rtl/blinker_ctrl.sv
// Turn-signal/hazard controller: input sync + debounce, mode FSM, lamp drive.
// Optional lane-change comfort flashing is enabled by defining COMFORT_BLINK_EN.
module blinker_ctrl
  import blinker_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 1,
  parameter int DEB_CYC  = 16,
  parameter int COMF_N   = 3,
  parameter int FCNT_W   = 4
) (
  input logic           clk,
  input logic           reset,
  blinker_ctrl_if.slave bus
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0]     DEB_MAX  = DW'(DEB_CYC);
  localparam logic [FCNT_W-1:0] FMAX     = '1;
  localparam logic [FCNT_W-1:0] COMF_LIM = FCNT_W'(COMF_N);
`ifdef COMFORT_BLINK_EN
  localparam bit COMF_EN = 1'b1;
`else
  localparam bit COMF_EN = 1'b0;
`endif

  logic [2:0]    sync_p0, sync_p1;
  logic          e_last, e_acc;
  logic [1:0]    lev_last, lev_acc, lev;
  logic [DW-1:0] e_run, lev_run, e_run_nxt, lev_run_nxt;

  // Run length of identical synchronised samples, saturating at DEB_CYC.
  assign e_run_nxt   = (sync_p1[2] != e_last) ? DW'(1) :
                       ((e_run == DEB_MAX) ? DEB_MAX : e_run + DW'(1));
  assign lev_run_nxt = (sync_p1[1:0] != lev_last) ? DW'(1) :
                       ((lev_run == DEB_MAX) ? DEB_MAX : lev_run + DW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      e_last   <= 1'b0;
      e_acc    <= 1'b0;
      e_run    <= '0;
      lev_last <= LEV_OFF;
      lev_acc  <= LEV_OFF;
      lev_run  <= '0;
    end else begin
      sync_p0  <= {bus.E, bus.ADI};
      sync_p1  <= sync_p0;
      e_last   <= sync_p1[2];
      e_run    <= e_run_nxt;
      lev_last <= sync_p1[1:0];
      lev_run  <= lev_run_nxt;
      if (e_run_nxt == DEB_MAX)
        e_acc <= sync_p1[2];
      if (lev_run_nxt == DEB_MAX)
        lev_acc <= sync_p1[1:0];
    end
  end

  state_t            state, nxt;
  logic              clr, run, tick, blink, lamp_r, lamp_l;
  logic [1:0]        status;
  logic [FCNT_W-1:0] fcnt;

  assign lev = (lev_acc == LEV_INV) ? LEV_OFF : lev_acc;

  always_comb begin
    nxt = S_IDLE;
    if (e_acc)
      nxt = S_HAZARD;
    else if (lev == LEV_R)
      nxt = S_RIGHT;
    else if (lev == LEV_L)
      nxt = S_LEFT;
    else if (COMF_EN && fcnt < COMF_LIM) begin
      if (state == S_RIGHT || state == S_COMF_R)
        nxt = S_COMF_R;
      else if (state == S_LEFT || state == S_COMF_L)
        nxt = S_COMF_L;
    end
  end

  // Entering comfort keeps the running phase; every other change restarts it.
  assign clr = (nxt != state) && (nxt != S_COMF_R) && (nxt != S_COMF_L);
  assign run = (nxt != S_IDLE);

  blink_prescaler #(.HALF(HALF)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .run   (run),
    .tick  (tick),
    .blink (blink)
  );

  // Comfort exits the cycle after flash_cnt shows COMF_N, so the count is visible once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      status <= ST_IDLE;
      lamp_r <= 1'b0;
      lamp_l <= 1'b0;
      fcnt   <= '0;
    end else begin
      state  <= nxt;
      status <= status_of(nxt);
      lamp_r <= (nxt == S_RIGHT) || (nxt == S_COMF_R) || (nxt == S_HAZARD);
      lamp_l <= (nxt == S_LEFT)  || (nxt == S_COMF_L) || (nxt == S_HAZARD);
      if (clr)
        fcnt <= '0;
      else if (run && tick && blink && fcnt != FMAX)
        fcnt <= fcnt + FCNT_W'(1);
    end
  end

  assign bus.tick      = tick;
  assign bus.blink     = blink;
  assign bus.D         = blink & lamp_r;
  assign bus.I         = blink & lamp_l;
  assign bus.Status    = status;
  assign bus.flash_cnt = fcnt;
endmodule

// File: tb/tb_blinker_ctrl.sv
// Randomised + directed bench for blinker_ctrl against a behavioural timing model.
module tb_blinker_ctrl;
  localparam int HALF   = 10;
  localparam int DEB    = 4;
  localparam int COMF_N = 3;
  localparam int FMAX   = 15;
`ifdef COMFORT_BLINK_EN
  localparam bit COMF = 1'b1;
`else
  localparam bit COMF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  blinker_ctrl_if #(.FCNT_W(4)) bus ();

  blinker_ctrl #(
    .CLK_HZ(100), .BLINK_HZ(5), .DEB_CYC(DEB), .COMF_N(COMF_N), .FCNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Model: n = edges since reset, t0 = edge of last phase restart,
  // mode 0 idle / 1 right / 2 left / 3 hazard (same numbers as Status), comf = comfort flag.
  int   n, t0, mode;
  bit   comf, acc_e;
  int   acc_lev;
  bit   eq[$];
  int   lq[$];

  function automatic int exp_fc();
    int f;
    if (mode == 0) return 0;
    f = (n - t0 + HALF) / (2 * HALF);
    return (f > FMAX) ? FMAX : f;
  endfunction

  function automatic int exp_blink();
    return (mode != 0 && ((n - t0) / HALF) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int exp_tick();
    return (((n - t0) % HALF) == HALF - 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    n = 0; t0 = 0; mode = 0; comf = 1'b0; acc_e = 1'b0; acc_lev = 0;
    eq.delete(); lq.delete();
    for (int k = 0; k < DEB + 2; k++) begin
      eq.push_back(1'b0);
      lq.push_back(0);
    end
  endtask

  task automatic model_step();
    int lev, nm, fc0;
    bit nc, restart, same_e, same_l;
    fc0 = exp_fc();
    lev = (acc_lev == 3) ? 0 : acc_lev;
    nc = 1'b0;
    if (acc_e) nm = 3;
    else if (lev != 0) nm = lev;
    else if (COMF && (mode == 1 || mode == 2) && fc0 < COMF_N) begin
      nm = mode;
      nc = 1'b1;
    end else nm = 0;
    restart = (nm != mode) || (comf && !nc);
    n++;
    if (restart) t0 = n;
    mode = nm;
    comf = nc;
    // Pin value seen at this edge is accepted once its 2-cycle-delayed copy has DEB equal samples.
    eq.push_front(bus.E);
    lq.push_front(int'(bus.ADI));
    void'(eq.pop_back());
    void'(lq.pop_back());
    same_e = 1'b1;
    same_l = 1'b1;
    for (int k = 3; k < DEB + 2; k++) begin
      if (eq[k] != eq[2]) same_e = 1'b0;
      if (lq[k] != lq[2]) same_l = 1'b0;
    end
    if (same_e) acc_e = eq[2];
    if (same_l) acc_lev = lq[2];
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("tick",      int'(bus.tick),      exp_tick());
        chk("blink",     int'(bus.blink),     exp_blink());
        chk("D",         int'(bus.D),         (exp_blink() == 1 && (mode == 1 || mode == 3)) ? 1 : 0);
        chk("I",         int'(bus.I),         (exp_blink() == 1 && (mode == 2 || mode == 3)) ? 1 : 0);
        chk("Status",    int'(bus.Status),    mode);
        chk("flash_cnt", int'(bus.flash_cnt), exp_fc());
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  int fl;
  bit pd;

  initial begin
    bus.E = 1'b0;
    bus.ADI = 2'b00;
    #2 rst_n = 1'b0;
    started = 1'b1;
    cyc(3);
    chk("rst_status", int'(bus.Status), 0);
    chk("rst_blink",  int'(bus.blink),  0);
    chk("rst_fc",     int'(bus.flash_cnt), 0);
    rst_n = 1'b1;
    cyc(9);  chk("idle_tick_9",  int'(bus.tick), 1);
    cyc(1);  chk("idle_tick_10", int'(bus.tick), 0);
    cyc(9);  chk("idle_tick_19", int'(bus.tick), 1);

    // Right lever held: Status after 7 cycles, 10 on / 10 off, flash counter saturates.
    bus.ADI = 2'b01;
    cyc(6);   chk("lat_before", int'(bus.Status), 0);
    cyc(1);   chk("lat_status", int'(bus.Status), 1);
              chk("lat_d",      int'(bus.D), 1);
    cyc(9);   chk("on_last_d",  int'(bus.D), 1);
    cyc(1);   chk("off_first_d", int'(bus.D), 0);
              chk("fc_1",       int'(bus.flash_cnt), 1);
    cyc(73);  chk("fc_4",       int'(bus.flash_cnt), 4);
    cyc(240); chk("fc_sat",     int'(bus.flash_cnt), 15);
    bus.ADI = 2'b00;
    cyc(30);

    // Short glitch is rejected by the debounce.
    bus.ADI = 2'b01;
    cyc(3);
    bus.ADI = 2'b00;
    cyc(12);  chk("glitch_status", int'(bus.Status), 0);

    // Left, then hazard mid on-phase, then back to left.
    bus.ADI = 2'b10;
    cyc(10);  chk("left_on", int'(bus.I), 1);
    bus.E = 1'b1;
    cyc(7);   chk("haz_status", int'(bus.Status), 3);
              chk("haz_d", int'(bus.D), 1);
              chk("haz_i", int'(bus.I), 1);
    bus.E = 1'b0;
    cyc(7);   chk("back_left", int'(bus.Status), 2);
              chk("back_left_i", int'(bus.I), 1);
              chk("back_left_d", int'(bus.D), 0);
    bus.ADI = 2'b00;
    cyc(80);  chk("left_done", int'(bus.Status), 0);

    // Lane-change tap: 15 cycles of right lever.
    bus.ADI = 2'b01;
    fl = 0;
    pd = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 15) bus.ADI = 2'b00;
      cyc(1);
      if (bus.D && !pd) fl++;
      pd = bus.D;
    end
    chk("tap_flashes", fl, COMF ? 3 : 1);
    chk("tap_idle", int'(bus.Status), 0);

    // Asynchronous reset during the hazard on-phase.
    bus.E = 1'b1;
    cyc(9);   chk("pre_rst_d", int'(bus.D), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_d",      int'(bus.D), 0);
    chk("async_i",      int'(bus.I), 0);
    chk("async_blink",  int'(bus.blink), 0);
    chk("async_status", int'(bus.Status), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);   chk("reacc_before", int'(bus.Status), 0);
    cyc(1);   chk("reacc_haz",    int'(bus.Status), 3);
    bus.E = 1'b0;
    cyc(20);

    for (int s = 0; s < 40; s++) begin
      bus.E   = ($urandom_range(0, 5) == 0);
      bus.ADI = 2'($urandom_range(0, 3));
      cyc($urandom_range(1, 45));
    end
    bus.E = 1'b0;
    bus.ADI = 2'b00;
    cyc(100);
    chk("final_idle", int'(bus.Status), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
